// File: rtl/nf_i_dq.sv
// nf_i_dq: pre-decoding instruction queue between fetch and execute
module nf_i_dq #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_ra1,
  output logic [4:0]       out_ra2,
  output logic [4:0]       out_wa3,
  output logic [2:0]       out_fmt,
  output logic [31:0]      out_imm,
  output logic             out_ill,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]     instr_q [DEPTH];
  logic [PC_W-1:0] pc_q    [DEPTH];
  logic [2:0]      fmt_q   [DEPTH];
  logic [31:0]     imm_q   [DEPTH];
  logic [AW-1:0]   rptr, wptr;
  logic [4:0]      op;
  logic [2:0]      fmt;
  logic [31:0]     imm;
  logic            push, pop;
  assign in_rdy  = count < CNT_W'(DEPTH);
  assign out_vld = count != '0;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;
  always_comb begin
    op  = in_instr[6:2];
    fmt = in_instr[1:0] != 2'b11 ? 3'd7 :
          op == 5'b01100 ? 3'd0 :
          (op == 5'b00100 || op == 5'b00000 || op == 5'b11001 ||
           op == 5'b11100 || op == 5'b00011) ? 3'd1 :
          op == 5'b01000 ? 3'd2 :
          op == 5'b11000 ? 3'd3 :
          (op == 5'b01101 || op == 5'b00101) ? 3'd4 :
          op == 5'b11011 ? 3'd5 : 3'd7;
    imm = fmt == 3'd1 ? {{20{in_instr[31]}}, in_instr[31:20]} :
          fmt == 3'd2 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
          fmt == 3'd3 ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
          fmt == 3'd4 ? {in_instr[31:12], 12'b0} :
          fmt == 3'd5 ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
          32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        fmt_q[i]   <= '0;
        imm_q[i]   <= '0;
      end
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        instr_q[wptr] <= in_instr;
        pc_q[wptr]    <= in_pc;
        fmt_q[wptr]   <= fmt;
        imm_q[wptr]   <= imm;
        wptr          <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // Head fields come straight from storage; register addresses are fixed instruction bits.
  assign out_instr = instr_q[rptr];
  assign out_pc    = pc_q[rptr];
  assign out_fmt   = fmt_q[rptr];
  assign out_imm   = imm_q[rptr];
  assign out_ill   = fmt_q[rptr] == 3'd7;
  assign out_ra1   = out_instr[19:15];
  assign out_ra2   = out_instr[24:20];
  assign out_wa3   = out_instr[11:7];
endmodule

// File: tb/tb_nf_i_dq.sv
// tb_nf_i_dq: directed vector and sequence checks for nf_i_dq
module tb_nf_i_dq;
  logic        clk = 0, rst = 1, flush = 0, in_vld = 0, out_rdy = 0;
  logic        in_rdy, out_vld, out_ill;
  logic [31:0] in_instr = 0, in_pc = 0, out_instr, out_pc, out_imm;
  logic [4:0]  out_ra1, out_ra2, out_wa3;
  logic [2:0]  out_fmt, count;
  int          tests = 0, fails = 0;

  nf_i_dq #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_instr(in_instr), .in_pc(in_pc), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_instr(out_instr), .out_pc(out_pc), .out_ra1(out_ra1), .out_ra2(out_ra2),
    .out_wa3(out_wa3), .out_fmt(out_fmt), .out_imm(out_imm), .out_ill(out_ill),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  ra1, ra2, wa3;
  } vec_t;
  vec_t v [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    v[0] = '{32'hFFF00093, 32'h100, 3'd1, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd31, 5'd1};
    v[1] = '{32'hFE000EE3, 32'h104, 3'd3, 32'hFFFFFFFC, 1'b0, 5'd0, 5'd0, 5'd29};
    v[2] = '{32'h123452B7, 32'h108, 3'd4, 32'h12345000, 1'b0, 5'd8, 5'd3, 5'd5};
    v[3] = '{32'h00000000, 32'h10C, 3'd7, 32'h00000000, 1'b1, 5'd0, 5'd0, 5'd0};
    v[4] = '{32'h00512423, 32'h110, 3'd2, 32'h00000008, 1'b0, 5'd2, 5'd5, 5'd8};
    v[5] = '{32'hFF9FF0EF, 32'h114, 3'd5, 32'hFFFFFFF8, 1'b0, 5'd31, 5'd25, 5'd1};
    v[6] = '{32'h00000001, 32'h118, 3'd7, 32'h00000000, 1'b1, 5'd0, 5'd0, 5'd0};
    v[7] = '{32'h0000007F, 32'h11C, 3'd7, 32'h00000000, 1'b1, 5'd0, 5'd0, 5'd0};
    v[8] = '{32'h002081B3, 32'h120, 3'd0, 32'h00000000, 1'b0, 5'd1, 5'd2, 5'd3};

    tick();
    tick();
    rst = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_in_rdy", 32'(in_rdy), 1);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_imm", out_imm, 0);

    // each vector: push, inspect head a cycle later, pop
    for (int i = 0; i < 9; i++) begin
      in_vld = 1; in_instr = v[i].instr; in_pc = v[i].pc;
      tick();
      in_vld = 0;
      chk("vec_out_vld", 32'(out_vld), 1);
      chk("vec_count", 32'(count), 1);
      chk("vec_instr", out_instr, v[i].instr);
      chk("vec_pc", out_pc, v[i].pc);
      chk("vec_fmt", 32'(out_fmt), 32'(v[i].fmt));
      chk("vec_imm", out_imm, v[i].imm);
      chk("vec_ill", 32'(out_ill), 32'(v[i].ill));
      chk("vec_ra1", 32'(out_ra1), 32'(v[i].ra1));
      chk("vec_ra2", 32'(out_ra2), 32'(v[i].ra2));
      chk("vec_wa3", 32'(out_wa3), 32'(v[i].wa3));
      out_rdy = 1;
      tick();
      out_rdy = 0;
      chk("vec_drained", 32'(count), 0);
    end

    out_rdy = 1;
    tick();
    chk("empty_no_underflow", 32'(count), 0);
    chk("empty_out_vld", 32'(out_vld), 0);
    out_rdy = 0;

    // fill to full with a stalled consumer, starting mid-buffer so pointers wrap
    for (int i = 0; i < 5; i++) begin
      in_vld = 1; in_instr = 32'h00000013 | (i << 7); in_pc = 32'h200 + 4 * i;
      tick();
      if (i == 3) begin
        chk("full_in_rdy", 32'(in_rdy), 0);
        chk("full_count", 32'(count), 4);
      end
    end
    in_vld = 0;
    chk("full_5th_rejected", 32'(count), 4);
    out_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_vld", 32'(out_vld), 1);
      chk("drain_pc", out_pc, 32'h200 + 4 * i);
      chk("drain_wa3", 32'(out_wa3), i);
      tick();
    end
    out_rdy = 0;
    chk("drain_empty", 32'(count), 0);

    // flush beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      in_vld = 1; in_instr = 32'h00000013; in_pc = 32'h300 + 4 * i;
      tick();
    end
    chk("pre_flush_count", 32'(count), 3);
    in_pc = 32'h3F0; out_rdy = 1; flush = 1;
    tick();
    flush = 0; out_rdy = 0;
    chk("flush_count", 32'(count), 0);
    chk("flush_out_vld", 32'(out_vld), 0);
    chk("flush_in_rdy", 32'(in_rdy), 1);
    in_pc = 32'h3F4;
    tick();
    in_vld = 0;
    chk("post_flush_count", 32'(count), 1);
    chk("post_flush_pc", out_pc, 32'h3F4);
    out_rdy = 1;
    tick();
    out_rdy = 0;

    // steady stream at occupancy 2
    in_vld = 1;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h400 + 4 * i;
      tick();
    end
    out_rdy = 1;
    for (int k = 0; k < 20; k++) begin
      in_pc = 32'h408 + 4 * k;
      chk("stream_count", 32'(count), 2);
      chk("stream_pc", out_pc, 32'h400 + 4 * k);
      tick();
    end
    in_vld = 0; out_rdy = 0;
    chk("stream_end_count", 32'(count), 2);

    // reset mid-burst clears everything, including storage
    in_vld = 1; in_pc = 32'h500; rst = 1;
    tick();
    rst = 0; in_vld = 0;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_vld", 32'(out_vld), 0);
    chk("midrst_out_pc", out_pc, 0);
    chk("midrst_out_instr", out_instr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
